// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer for the 8-bit accumulator CPU.
// Walks each instruction through fetch/decode/execute phases, waits on the
// multicycle float adder for ADD, and handles halt/resume and adder timeout.
module cpu_ctrl_seq #(
  parameter int ADD_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  input  logic       alu_done,
  input  logic       run,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       alu_start,
  output logic       halt,
  output logic       add_timeout,
  output logic [3:0] phase
);

  localparam logic [2:0] OPC_HLT = 3'b000;
  localparam logic [2:0] OPC_SKZ = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_AND = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_LDA = 3'b101;
  localparam logic [2:0] OPC_STO = 3'b110;
  localparam logic [2:0] OPC_JMP = 3'b111;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ADD_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_ALU_WAIT   = 4'd8,
    ST_HALTED     = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             add_timeout_q, add_timeout_d;
  logic             aluop;

  assign aluop = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                 (opcode == OPC_XOR) || (opcode == OPC_LDA);

  // Next-state, adder wait counter and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    add_timeout_d = add_timeout_q;
    case (state_q)
      ST_INST_ADDR:  state_d = ST_INST_FETCH;
      ST_INST_FETCH: state_d = ST_INST_LOAD;
      ST_INST_LOAD:  state_d = ST_IDLE;
      ST_IDLE:       state_d = ST_OP_ADDR;
      ST_OP_ADDR:    state_d = (opcode == OPC_HLT) ? ST_HALTED : ST_OP_FETCH;
      ST_OP_FETCH:   state_d = ST_ALU_OP;
      ST_ALU_OP:     state_d = (opcode == OPC_ADD) ? ST_ALU_WAIT : ST_STORE;
      ST_ALU_WAIT: begin
        if (alu_done) begin
          state_d = ST_STORE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d       = ST_HALTED;
          add_timeout_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STORE:      state_d = ST_INST_ADDR;
      ST_HALTED: begin
        if (run && !add_timeout_q) state_d = ST_INST_ADDR;
      end
      default: begin
        state_d = ST_INST_ADDR;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INST_ADDR;
      cnt_q         <= '0;
      add_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      add_timeout_q <= add_timeout_d;
    end
  end

  // Control decode from the current phase and the instruction in IR.
  always_comb begin
    sel       = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    ld_ir     = 1'b0;
    ld_ac     = 1'b0;
    inc_pc    = 1'b0;
    ld_pc     = 1'b0;
    data_e    = 1'b0;
    alu_start = 1'b0;
    halt      = 1'b0;
    case (state_q)
      ST_INST_ADDR: sel = 1'b1;
      ST_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      ST_INST_LOAD, ST_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      ST_OP_ADDR:  inc_pc = 1'b1;
      ST_OP_FETCH: rd = aluop;
      ST_ALU_OP: begin
        rd        = aluop;
        inc_pc    = (opcode == OPC_SKZ) && is_zero;
        ld_pc     = (opcode == OPC_JMP);
        data_e    = (opcode == OPC_STO);
        alu_start = (opcode == OPC_ADD);
      end
      ST_ALU_WAIT: rd = 1'b1;
      ST_STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (opcode == OPC_JMP);
        data_e = (opcode == OPC_STO);
        wr     = (opcode == OPC_STO);
      end
      ST_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign add_timeout = add_timeout_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Randomized bench for cpu_ctrl_seq with an instruction-level reference model.
module tb_cpu_ctrl_seq;

  localparam int ADD_WAIT_MAX = 15;
  localparam int CNT_W        = 8;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic alu_start;
    logic halt;
  } ctl_t;

  typedef struct packed {
    logic [3:0] ph;
    ctl_t       c;
    logic       to;
    logic [2:0] op;
    logic       iz;
    logic       ad;
    logic       rn;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       is_zero;
  logic       alu_done;
  logic       run;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, alu_start, halt;
  logic       add_timeout;
  logic [3:0] phase;

  vec_t exp_q[$];
  logic exp_to;
  int   vectors = 0;
  int   miscompares = 0;

  cpu_ctrl_seq #(.ADD_WAIT_MAX(ADD_WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
    .alu_done(alu_done), .run(run), .sel(sel), .rd(rd), .wr(wr),
    .ld_ir(ld_ir), .ld_ac(ld_ac), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .data_e(data_e), .alu_start(alu_start), .halt(halt),
    .add_timeout(add_timeout), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input logic [3:0] ph, input logic [2:0] op, input logic iz,
                      input logic ad, input logic rn, input ctl_t c);
    vec_t v;
    v.ph = ph; v.c = c; v.to = exp_to; v.op = op; v.iz = iz; v.ad = ad; v.rn = rn;
    exp_q.push_back(v);
  endtask

  // Reference model: expected per-cycle behaviour of one whole instruction.
  // k = ALU_WAIT cycles until alu_done (0 = adder never answers),
  // nh = halted cycles with run low before the resume pulse.
  task automatic gen_instr(input logic [2:0] op, input int k, input int nh);
    ctl_t c;
    logic aluop;
    logic iz;
    int   n;
    aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    for (int i = 0; i < 4; i++) begin
      c = '0; c.sel = 1'b1; c.rd = (i > 0); c.ld_ir = (i > 1);
      push(4'(i), rop(), rbit(), rbit(), rbit(), c);
    end
    c = '0; c.inc_pc = 1'b1;
    push(4'd4, op, rbit(), rbit(), rbit(), c);
    if (op == HLT) begin
      c = '0; c.halt = 1'b1;
      for (int i = 0; i < nh; i++) push(4'd9, rop(), rbit(), rbit(), 1'b0, c);
      push(4'd9, rop(), rbit(), rbit(), 1'b1, c);
      return;
    end
    c = '0; c.rd = aluop;
    push(4'd5, op, rbit(), rbit(), rbit(), c);
    iz = rbit();
    c = '0; c.rd = aluop; c.inc_pc = (op == SKZ) && iz; c.ld_pc = (op == JMP);
    c.data_e = (op == STO); c.alu_start = (op == ADD);
    push(4'd6, op, iz, rbit(), rbit(), c);
    if (op == ADD) begin
      n = (k == 0) ? ADD_WAIT_MAX : k;
      c = '0; c.rd = 1'b1;
      for (int i = 0; i < n; i++) push(4'd8, op, rbit(), (k != 0) && (i == n - 1), rbit(), c);
      if (k == 0) begin
        exp_to = 1'b1;
        c = '0; c.halt = 1'b1;
        for (int i = 0; i < 6; i++) push(4'd9, rop(), rbit(), rbit(), 1'b1, c);
        return;
      end
    end
    c = '0; c.rd = aluop; c.ld_ac = aluop; c.ld_pc = (op == JMP);
    c.data_e = (op == STO); c.wr = (op == STO);
    push(4'd7, op, rbit(), rbit(), rbit(), c);
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] exp);
    logic [14:0] got;
    got = {phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, alu_start, halt, add_timeout};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s ph=%0d got=%b exp=%b", tag, exp[14:11], got, exp);
    end
  endtask

  // Drives each queued cycle after the rising edge and checks mid-cycle.
  task automatic applyStimulus();
    vec_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      opcode = e.op; is_zero = e.iz; alu_done = e.ad; run = e.rn;
      @(negedge clk);
      checkOutput("cycle", {e.ph, e.c, e.to});
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [14:0] reset_vec();
    ctl_t c;
    c = '0; c.sel = 1'b1;
    return {4'd0, c, 1'b0};
  endfunction

  initial begin
    exp_to = 1'b0;
    rst = 1'b1; opcode = 3'b000; is_zero = 1'b0; alu_done = 1'b0; run = 1'b0;
    #1;
    checkOutput("reset_async", reset_vec());
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: LDA, ADD finishing on 3rd wait cycle, ADD finishing on last legal cycle, long halt.
    gen_instr(LDA, 0, 0);               applyStimulus();
    gen_instr(ADD, 3, 0);               applyStimulus();
    gen_instr(ADD, ADD_WAIT_MAX, 0);    applyStimulus();
    gen_instr(HLT, 0, 20);              applyStimulus();
    gen_instr(SKZ, 0, 0);               applyStimulus();
    gen_instr(STO, 0, 0);               applyStimulus();
    gen_instr(JMP, 0, 0);               applyStimulus();

    // Random instruction stream with random don't-care inputs.
    for (int i = 0; i < 80; i++) begin
      gen_instr(rop(), $urandom_range(1, ADD_WAIT_MAX), $urandom_range(0, 4));
      applyStimulus();
    end

    // Reset in the third ALU_WAIT cycle aborts the ADD.
    gen_instr(ADD, 5, 0);
    exp_q = exp_q[0:8];
    applyStimulus();
    alu_done = 1'b0; run = 1'b0;
    #2 rst = 1'b1;
    #1 checkOutput("reset_in_wait", reset_vec());
    @(negedge clk);
    checkOutput("reset_held", reset_vec());
    @(posedge clk); #1;
    rst = 1'b0;

    // Adder never answers: timeout after the full wait, run is then ignored.
    gen_instr(ADD, 0, 0);
    applyStimulus();

    // Asynchronous reset clears the sticky fault.
    run = 1'b1;
    #3 rst = 1'b1;
    exp_to = 1'b0;
    #1 checkOutput("reset_clears_timeout", reset_vec());
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Instruction sequencer for the 8-bit accumulator CPU built around the 3-bit-opcode ALU (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP; ADD is 8-bit float 1|3|4).
- Steps each instruction through eight fixed phases and drives the PC, IR, accumulator, memory and address-mux controls.
- Adds a handshake wait phase so a multicycle float adder can finish.
- Handles halt/resume and an adder-timeout fault.

Parameters:
ADD_WAIT_MAX, 15, maximum cycles spent in ALU_WAIT before timeout (legal range 1..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > ADD_WAIT_MAX

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  3  current IR opcode; valid from OP_ADDR onward
is_zero  in  1  ALU zero flag (accumulator == 0)
alu_done  in  1  float adder result valid; level, sampled in ALU_WAIT
run  in  1  resume request; only honoured in HALTED
sel  out  1  address mux: 1 = PC, 0 = IR operand field
rd  out  1  memory read enable
wr  out  1  memory write strobe
ld_ir  out  1  load instruction register
ld_ac  out  1  load accumulator from ALU result
inc_pc  out  1  increment PC
ld_pc  out  1  load PC from IR operand
data_e  out  1  drive accumulator onto data bus
alu_start  out  1  one-cycle start pulse to the float adder
halt  out  1  CPU halted
add_timeout  out  1  sticky fault: adder did not answer in time
phase  out  4  current state code, for debug

Behaviour:
- Clock and reset:
  - One clock domain: clk. Reset rst is asynchronous and active-high.
  - On reset: state = INST_ADDR, wait counter = 0, add_timeout = 0.
  - Outputs after reset are the INST_ADDR decode: sel=1, all other controls 0, phase=0.
- Registers: state and counter are registered. All control outputs are Moore/Mealy combinational decodes of (state, opcode, is_zero).
- Derived term: ALUOP = opcode is ADD, AND, XOR or LDA.
- State codes and outputs:
  - INST_ADDR(0): sel=1.
  - INST_FETCH(1): sel=1, rd=1.
  - INST_LOAD(2): sel=1, rd=1, ld_ir=1.
  - IDLE(3): sel=1, rd=1, ld_ir=1.
  - OP_ADDR(4): inc_pc=1. Next state is HALTED if opcode==HLT, else OP_FETCH.
  - OP_FETCH(5): rd=ALUOP.
  - ALU_OP(6): rd=ALUOP; inc_pc = (opcode==SKZ && is_zero); ld_pc = (opcode==JMP); data_e = (opcode==STO); alu_start = (opcode==ADD). Next state is ALU_WAIT if ADD, else STORE.
  - ALU_WAIT(8): rd=1.
    - Counter increments each cycle.
    - alu_done=1 → STORE, counter cleared.
    - Else if counter == ADD_WAIT_MAX-1 → HALTED, add_timeout set, counter cleared.
    - alu_done has priority over timeout in the same cycle.
  - STORE(7): rd=ALUOP, ld_ac=ALUOP, ld_pc=(JMP), data_e=(STO), wr=(STO). Next state is INST_ADDR.
  - HALTED(9): halt=1, all other controls 0.
    - run=1 → INST_ADDR. PC already points past the HLT.
    - If add_timeout=1, run is ignored; only reset clears it.
- Latency:
  - Non-ADD instruction: exactly 8 cycles.
  - ADD: 8 + k cycles, where k (1..ADD_WAIT_MAX) is the ALU_WAIT cycle count including the cycle alu_done is seen.
- Boundary conditions:
  - alu_done asserted outside ALU_WAIT is ignored.
  - run outside HALTED is ignored.
  - Reset mid-ALU_WAIT aborts the instruction immediately: no ld_ac or wr is issued, and the counter clears.
- Illegal state codes (10–15): recover to INST_ADDR on the next clock.

Test Plan:
1. Reset: assert rst mid-cycle → phase=0, sel=1, other controls 0, add_timeout=0, asynchronously before the next clk edge.
2. LDA (opcode=101), is_zero=0: phases go 0,1,2,3,4,5,6,7,0 → rd high in phases 1–3 and 5–7; ld_ac only in phase 7; inc_pc only in phase 4; 8 cycles total.
3. SKZ with is_zero=1 → inc_pc pulses in phases 4 and 6. SKZ with is_zero=0 → inc_pc pulses in phase 4 only. STO → wr=1 and data_e=1 in phase 7, data_e=1 in phase 6. JMP → ld_pc=1 in phases 6 and 7.
4. ADD (opcode=010), alu_done raised on the 3rd ALU_WAIT cycle:
   - alu_start is a single pulse in phase 6.
   - phase=8 for 3 cycles, then 7 with ld_ac=1.
   - Instruction takes 11 cycles.
5. ADD, alu_done never asserted, ADD_WAIT_MAX=15:
   - 15 ALU_WAIT cycles, then HALTED with add_timeout=1, halt=1, no ld_ac.
   - run=1 afterwards leaves the block in HALTED.
6. HLT (000) → OP_ADDR then HALTED, halt=1. Hold run=0 for 20 cycles → stays halted. Pulse run=1 → phase 0 on the next edge. Assert rst during ALU_WAIT → phase=0, counter 0, no wr or ld_ac.
